// File: rtl/uart_tx_drain_pkg.sv
// Shared types and constants for the FIFO-to-UART drain.
// Optional parity stage: define UART_TX_PARITY_EN.
package uart_pkg;

  localparam int DATA_W_DEF = 32;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

  function automatic int frame_cycles(
    input int clks_per_bit,
    input bit parity
  );
    return clks_per_bit *
      (UART_DATA_BITS + 2 + (parity ? 1 : 0));
  endfunction

endpackage

// File: rtl/uart_tx_drain_if.sv
// FIFO read port and UART pin bundle.
// master: the drain; slave: FIFO/pin side.
interface uart_tx_drain_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] fifo_data_out;
  logic              fifo_empty;
  logic              fifo_read_enabled;
  logic              tx;
  logic              busy;

  modport master (
    input  fifo_data_out,
    input  fifo_empty,
    output fifo_read_enabled,
    output tx,
    output busy
  );

  modport slave (
    output fifo_data_out,
    output fifo_empty,
    input  fifo_read_enabled,
    input  tx,
    input  busy
  );
endinterface

// File: rtl/uart_tx_drain_baud_tick.sv
// Bit-period counter with synchronous clear.
// bit_done pulses on the last cycle of each bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_done
);
  localparam int TW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST =
    TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt_q;
  logic          last;

  assign last     = (cnt_q == LAST);
  assign bit_done = last & ~clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || last) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx_drain.sv
// Pops FIFO words and sends the low byte as a UART frame.
// Define UART_TX_PARITY_EN for an even-parity bit.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = DATA_W_DEF
) (
  input logic             clk,
  input logic             rst_n,
  uart_tx_drain_if.master bus
);
  tx_state_t   state_q, state_d;
  logic [7:0]  sreg_q, sreg_d;
  logic [2:0]  bit_q, bit_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;
  logic        pop;
  logic        clear;
  logic        bit_done;
  logic [DATA_W-1:0] unused_word;

  assign unused_word = bus.fifo_data_out;

  assign clear = (state_q == IDLE) ||
                 (state_q == FETCH);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .bit_done(bit_done)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bit_d   = bit_q;
    par_d   = par_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.fifo_empty) begin
          pop     = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        sreg_d  = bus.fifo_data_out[7:0];
        par_d   = ^bus.fifo_data_out[7:0];
        bit_d   = '0;
        state_d = START;
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          sreg_d = sreg_q >> 1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (!bus.fifo_empty) begin
            pop     = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the next state so it changes only on edges
  always_comb begin
    tx_d = UART_IDLE_LEVEL;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= UART_IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.fifo_read_enabled = pop;
  assign bus.tx                = tx_q;
  assign bus.busy              = (state_q != IDLE);
endmodule
